tx_frame_ctrl: RTL and testbench
================================

// Module: tx_frame_ctrl
// PURPOSE
// - Symbol-rate frame sequencer for the transmit chain; runs on sys_clk from clk_gen and advances only on sym_clk_ena.
// - Emits one frame per start: PREAMBLE_LEN training symbols, then payload_len payload symbols pulled from the upstream source.
// - After the payload, emits GUARD_LEN guard symbols, then returns to idle.
// - Drives the 2-bit symbol into the pulse-shaping / modulator datapath.
// PARAMETERS
// - PREAMBLE_LEN  8      preamble symbols per frame (>=1)
// - GUARD_LEN     2      guard symbols per frame (>=1)
// - LEN_W         8      width of payload_len and the payload counter
// - GUARD_SYM     2'b00  symbol value sent during GUARD
// PORTS
// - sys_clk      in   1      system clock (clk_gen sys_clk)
// - reset        in   1      synchronous, active-high reset
// - sym_clk_ena  in   1      one-cycle symbol strobe (clk_gen, phase 0)
// - start        in   1      frame request pulse, any sys_clk cycle
// - payload_len  in   LEN_W  payload symbol count, captured at frame start
// - data_valid   in   1      source has a symbol on data_in
// - data_in      in   2      payload symbol
// - data_ready   out  1      pop strobe to source (one cycle)
// - sym_out      out  2      current transmit symbol
// - sym_valid    out  1      high while a frame symbol is on sym_out
// - busy         out  1      start pending or frame in progress
// - done         out  1      one-cycle end-of-frame pulse
// - underflow    out  1      sticky: payload slot had no data
// - state        out  2      IDLE=0, PREAMBLE=1, PAYLOAD=2, GUARD=3
// BEHAVIOUR
// - Reset values: state=IDLE, sym_out=0, sym_valid=0, data_ready=0, busy=0, done=0, underflow=0, counters=0, start_pend=0.
// - Registers update every sys_clk. State, counters and sym_out change only in cycles with sym_clk_ena=1 (except start_pend and reset).
// - start in IDLE sets start_pend; a start pulse while not IDLE is ignored.
// - busy = start_pend | (state!=IDLE).
// - IDLE with sym_clk_ena and (start_pend|start): go PREAMBLE, capture payload_len, clear start_pend, load first preamble symbol.
// - PREAMBLE: emit PREAMBLE_LEN symbols, alternating 2'b11, 2'b00, starting 2'b11.
//   After the last one: go to PAYLOAD if the captured length != 0, else go to GUARD.
// - PAYLOAD: data_ready is combinational: (state==PAYLOAD) & sym_clk_ena & remaining != 0.
//   - If data_valid in that cycle: sym_out <= data_in.
//   - Otherwise: sym_out <= 2'b00 and underflow <= 1.
//   - The count decrements either way. After the last payload symbol, go to GUARD.
// - GUARD: emit GUARD_SYM for GUARD_LEN symbols. On the sym_clk_ena ending the last one: go IDLE, done=1 for that cycle, sym_valid<=0.
// - sym_valid is registered. It is set with the first preamble symbol, cleared on the GUARD->IDLE transition, and held between strobes.
// - Each symbol occupies exactly one symbol period (16 sys_clk). There are no gap symbols between phases.
// - Latency: start arriving before a strobe -> first preamble symbol on sym_out one cycle after that strobe.
// - Frame length = PREAMBLE_LEN + payload_len + GUARD_LEN symbol periods.
// - payload_len = max (2^LEN_W - 1): the counter must not wrap. Exactly 2^LEN_W - 1 payload symbols are sent.
// - underflow clears only on reset. It is not cleared by a new frame.
// - Reset asserted mid-frame: all outputs return to reset values next cycle. No done pulse; the partial frame is abandoned.
// - start and reset in the same cycle: reset wins and start is dropped.
// CONFIGURATION
// - TX_FRAME_PN_PREAMBLE_EN defined:
//   - Preamble uses a 7-bit LFSR (x^7+x^6+1), seeded to 7'h7F at frame start.
//   - sym_out = {lfsr[6],lfsr[6]}; the LFSR shifts once per preamble symbol.
// - TX_FRAME_PN_PREAMBLE_EN undefined: alternating 11/00 preamble; no LFSR logic is built.
// TESTING
// - Reset, then start with payload_len=3 and data_valid=1, data_in = 01,10,11.
//   Required sym_out per strobe (default build): 11,00,11,00,11,00,11,00,01,10,11,00,00.
//   done pulses once on the 14th strobe; underflow stays 0.
// - payload_len=0 -> 8 preamble + 2 guard symbols; data_ready never asserts; done on the 11th strobe.
// - data_valid=0 on the 2nd of 4 payload slots -> that symbol = 00, underflow=1 and sticky through a second clean frame.
// - Timing: start 5 cycles before a strobe, and a second start mid-frame.
//   Frame begins at that strobe; the second start is ignored; busy high from the cycle after start until done.
// - Reset asserted during PAYLOAD -> next cycle state=0, sym_valid=0, sym_out=0, no done; next start runs a full frame.
// - TX_FRAME_PN_PREAMBLE_EN build: first three preamble symbols are 11,11,11 (seed 7'h7F). The sequence repeats every 127 symbols.

Source files
------------

// File: rtl/tx_frame_ctrl_if.sv
// tx_frame_ctrl_if: bundles the frame request, the payload source handshake
// and the transmit symbol outputs of tx_frame_ctrl.
// The master side drives the requests and the payload, and the slave side is the sequencer.
interface tx_frame_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] payload_len;
  logic             data_valid;
  logic [1:0]       data_in;
  logic             data_ready;
  logic [1:0]       sym_out;
  logic             sym_valid;
  logic             busy;
  logic             done;
  logic             underflow;
  logic [1:0]       state;

  modport master (
    output start, payload_len, data_valid, data_in,
    input  data_ready, sym_out, sym_valid, busy, done, underflow, state
  );

  modport slave (
    input  start, payload_len, data_valid, data_in,
    output data_ready, sym_out, sym_valid, busy, done, underflow, state
  );
endinterface

// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: symbol-rate frame sequencer for the transmit chain.
// Each frame has three parts: preamble, then payload pulled from the source, then guard symbols.
// The state, the counters and sym_out move only on sym_clk_ena.
// Optional build macro TX_FRAME_PN_PREAMBLE_EN: the preamble comes from a
// 7-bit LFSR (x^7+x^6+1, seed 7'h7F) instead of the alternating 11/00 pattern.
//
// state    | meaning
// IDLE     | no frame, waiting for start / start_pend at a strobe
// PREAMBLE | loading preamble symbols; leaves on the strobe loading the last
// PAYLOAD  | popping payload symbols; leaves on the strobe loading the last
// GUARD    | loading guard symbols; the strobe after the last ends the frame
module tx_frame_ctrl #(
  parameter int         PREAMBLE_LEN = 8,
  parameter int         GUARD_LEN    = 2,
  parameter int         LEN_W        = 8,
  parameter logic [1:0] GUARD_SYM    = 2'b00
) (
  input  logic           sys_clk,
  input  logic           reset,
  input  logic           sym_clk_ena,
  tx_frame_ctrl_if.slave bus
);
  localparam int PH_MAX = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] PRE_LOAD   = PH_W'(PREAMBLE_LEN - 1);
  localparam logic [PH_W-1:0] GUARD_LOAD = PH_W'(GUARD_LEN);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    GUARD    = 2'd3
  } state_t;

  state_t           state_q, state_nxt;
  logic [1:0]       sym_q, sym_nxt;
  logic             valid_q, valid_nxt;
  logic             done_q, done_nxt;
  logic             under_q, under_nxt;
  logic             pend_q, pend_nxt;
  logic [LEN_W-1:0] rem_q, rem_nxt;
  logic [PH_W-1:0]  ph_q, ph_nxt;
  logic             ready;

`ifdef TX_FRAME_PN_PREAMBLE_EN
  logic [6:0] lfsr_q, lfsr_nxt;

  function automatic logic [6:0] lfsr_step(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction
`endif

  // Register all sequencer state; reset abandons any frame without a done pulse.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
      sym_q   <= 2'b00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
      pend_q  <= 1'b0;
      rem_q   <= '0;
      ph_q    <= '0;
`ifdef TX_FRAME_PN_PREAMBLE_EN
      lfsr_q  <= 7'h7F;
`endif
    end else begin
      state_q <= state_nxt;
      sym_q   <= sym_nxt;
      valid_q <= valid_nxt;
      done_q  <= done_nxt;
      under_q <= under_nxt;
      pend_q  <= pend_nxt;
      rem_q   <= rem_nxt;
      ph_q    <= ph_nxt;
`ifdef TX_FRAME_PN_PREAMBLE_EN
      lfsr_q  <= lfsr_nxt;
`endif
    end
  end

  // Next-state and symbol selection; every phase loads its next symbol on the strobe.
  always_comb begin
    state_nxt = state_q;
    sym_nxt   = sym_q;
    valid_nxt = valid_q;
    done_nxt  = 1'b0;
    under_nxt = under_q;
    pend_nxt  = pend_q;
    rem_nxt   = rem_q;
    ph_nxt    = ph_q;
    ready     = 1'b0;
`ifdef TX_FRAME_PN_PREAMBLE_EN
    lfsr_nxt  = lfsr_q;
`endif

    if (state_q == IDLE && bus.start) pend_nxt = 1'b1;

    if (sym_clk_ena) begin
      case (state_q)
        IDLE: begin
          if (pend_q || bus.start) begin
            pend_nxt  = 1'b0;
            rem_nxt   = bus.payload_len;
            sym_nxt   = 2'b11;
            valid_nxt = 1'b1;
            ph_nxt    = PRE_LOAD;
`ifdef TX_FRAME_PN_PREAMBLE_EN
            lfsr_nxt  = lfsr_step(7'h7F);
`endif
            if (PREAMBLE_LEN == 1) begin
              state_nxt = (bus.payload_len != '0) ? PAYLOAD : GUARD;
              ph_nxt    = GUARD_LOAD;
            end else begin
              state_nxt = PREAMBLE;
            end
          end
        end
        PREAMBLE: begin
`ifdef TX_FRAME_PN_PREAMBLE_EN
          sym_nxt  = {2{lfsr_q[6]}};
          lfsr_nxt = lfsr_step(lfsr_q);
`else
          sym_nxt  = ~sym_q;
`endif
          ph_nxt = ph_q - PH_W'(1);
          if (ph_q == PH_W'(1)) begin
            state_nxt = (rem_q != '0) ? PAYLOAD : GUARD;
            ph_nxt    = GUARD_LOAD;
          end
        end
        PAYLOAD: begin
          if (rem_q != '0) begin
            ready   = 1'b1;
            rem_nxt = rem_q - LEN_W'(1);
            if (bus.data_valid) begin
              sym_nxt = bus.data_in;
            end else begin
              sym_nxt   = 2'b00;
              under_nxt = 1'b1;
            end
          end
          if (rem_q <= LEN_W'(1)) begin
            state_nxt = GUARD;
            ph_nxt    = GUARD_LOAD;
          end
        end
        GUARD: begin
          if (ph_q != '0) begin
            sym_nxt = GUARD_SYM;
            ph_nxt  = ph_q - PH_W'(1);
          end else begin
            state_nxt = IDLE;
            sym_nxt   = 2'b00;
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.data_ready = ready;
  assign bus.sym_out    = sym_q;
  assign bus.sym_valid  = valid_q;
  assign bus.busy       = pend_q | (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.underflow  = under_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_tx_frame_ctrl.sv
// tb_tx_frame_ctrl: scoreboard bench for tx_frame_ctrl. The driver pushes
// the expected symbol stream of each frame and a monitor pops and compares it
// on every symbol strobe.
module tb_tx_frame_ctrl;
  localparam int PRE   = 8;
  localparam int GUARD = 2;
  localparam int LEN_W = 8;

  logic sys_clk = 1'b0;
  logic reset;
  logic sym_clk_ena;

  tx_frame_ctrl_if #(.LEN_W(LEN_W)) bus ();

  tx_frame_ctrl #(
    .PREAMBLE_LEN(PRE),
    .GUARD_LEN   (GUARD),
    .LEN_W       (LEN_W),
    .GUARD_SYM   (2'b00)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sym_clk_ena(sym_clk_ena),
    .bus        (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_sym[$];
  int         frames[$];
  logic [2:0] plan[$];
  logic [2:0] slots[$];
  logic       exp_under = 1'b0;
  logic       aborting = 1'b0;
  logic       ready_seen = 1'b0;
  int         ready_total = 0;
  int         ready_mark = 0;
  int         ph = 15;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #3;
  endtask

  // one-cycle strobe every 16 sys_clk
  initial begin
    sym_clk_ena = 1'b0;
    forever begin
      @(posedge sys_clk);
      #2;
      ph = (ph + 1) % 16;
      sym_clk_ena = (ph == 0);
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      ready_seen = bus.data_ready;
      if (bus.data_ready) ready_total++;
    end
  end

  // payload source: presents the head of the plan, pops it when the DUT takes it
  initial begin
    bus.data_valid = 1'b0;
    bus.data_in    = 2'b00;
    forever begin
      @(posedge sys_clk);
      #2;
      if (ready_seen) begin
        check("pop_with_plan", 32'(plan.size() > 0), 32'd1);
        if (plan.size() > 0) void'(plan.pop_front());
      end
      if (plan.size() > 0) begin
        bus.data_valid = plan[0][2];
        bus.data_in    = plan[0][1:0];
      end else begin
        bus.data_valid = 1'b0;
        bus.data_in    = 2'($urandom);
      end
    end
  end

  // monitor: one expected symbol per strobe, then a done pulse closes the frame
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (!aborting && !reset) begin
        if (sym_clk_ena && frames.size() > 0) begin
          if (exp_sym.size() > 0) begin
            check("sym_valid", 32'(bus.sym_valid), 32'd1);
            check("done_early", 32'(bus.done), 32'd0);
            check("sym_out", 32'(bus.sym_out), 32'(exp_sym.pop_front()));
          end else begin
            check("done", 32'(bus.done), 32'd1);
            check("done_state", 32'(bus.state), 32'd0);
            check("done_sym_valid", 32'(bus.sym_valid), 32'd0);
            check("done_busy", 32'(bus.busy), 32'd0);
            check("underflow", 32'(bus.underflow), 32'(exp_under));
            check("ready_count", 32'(ready_total - ready_mark), 32'(frames[0]));
            void'(frames.pop_front());
          end
        end else begin
          check("no_done", 32'(bus.done), 32'd0);
          if (frames.size() == 0 && sym_clk_ena)
            check("idle_sym_valid", 32'(bus.sym_valid), 32'd0);
        end
      end
    end
  end

  // expected stream of one frame, derived from the frame format
  task automatic push_frame(input int len);
`ifdef TX_FRAME_PN_PREAMBLE_EN
    logic [6:0] lf;
    lf = 7'h7F;
`endif
    for (int i = 0; i < PRE; i++) begin
`ifdef TX_FRAME_PN_PREAMBLE_EN
      exp_sym.push_back({lf[6], lf[6]});
      lf = {lf[5:0], lf[6] ^ lf[5]};
`else
      exp_sym.push_back((i % 2 == 0) ? 2'b11 : 2'b00);
`endif
    end
    for (int i = 0; i < len; i++) begin
      plan.push_back(slots[i]);
      exp_sym.push_back(slots[i][2] ? slots[i][1:0] : 2'b00);
      if (!slots[i][2]) exp_under = 1'b1;
    end
    for (int i = 0; i < GUARD; i++) exp_sym.push_back(2'b00);
    frames.push_back(len);
  endtask

  task automatic start_frame(input int len);
    push_frame(len);
    ready_mark      = ready_total;
    bus.payload_len = LEN_W'(len);
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (frames.size() > 0 && n < budget) begin
      tick();
      n++;
      if (n == 20) bus.payload_len = LEN_W'($urandom);
    end
    if (frames.size() > 0) begin
      check("frame_timeout", 32'(frames.size()), 32'd0);
      frames.delete();
      exp_sym.delete();
      plan.delete();
    end
  endtask

  task automatic random_slots(input int len, input int bad_pct);
    slots.delete();
    for (int i = 0; i < len; i++)
      slots.push_back({($urandom_range(0, 99) >= bad_pct), 2'($urandom)});
  endtask

  initial begin
    int n;
    int len;
    reset           = 1'b1;
    aborting        = 1'b1;
    bus.start       = 1'b1;
    bus.payload_len = LEN_W'(3);
    repeat (3) tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    aborting  = 1'b0;
    tick();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_sym_out", 32'(bus.sym_out), 32'd0);
    check("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);
    check("rst_data_ready", 32'(bus.data_ready), 32'd0);
    repeat (40) tick();
    check("start_with_reset_dropped", 32'(bus.busy), 32'd0);

    // payload 01,10,11
    slots.delete();
    slots.push_back(3'b101);
    slots.push_back(3'b110);
    slots.push_back(3'b111);
    start_frame(3);
    wait_done(400);

    // empty payload
    slots.delete();
    start_frame(0);
    wait_done(400);

    // second of four slots starved, then a clean frame keeps underflow set
    slots.delete();
    slots.push_back(3'b110);
    slots.push_back(3'b011);
    slots.push_back(3'b101);
    slots.push_back(3'b111);
    start_frame(4);
    wait_done(400);
    random_slots(2, 0);
    start_frame(2);
    wait_done(400);

    // start 5 cycles before a strobe, plus an ignored start mid-frame
    n = 0;
    while (ph != 11 && n < 40) begin
      tick();
      n++;
    end
    random_slots(2, 0);
    start_frame(2);
    repeat (40) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_mid_frame", 32'(bus.busy), 32'd1);
    wait_done(400);
    repeat (20) tick();
    check("mid_start_ignored", 32'(bus.busy), 32'd0);

    // reset while sending payload
    random_slots(5, 0);
    start_frame(5);
    n = 0;
    while (bus.state != 2'd2 && n < 400) begin
      tick();
      n++;
    end
    check("reach_payload", 32'(bus.state), 32'd2);
    aborting = 1'b1;
    reset    = 1'b1;
    tick();
    check("abort_state", 32'(bus.state), 32'd0);
    check("abort_sym_valid", 32'(bus.sym_valid), 32'd0);
    check("abort_sym_out", 32'(bus.sym_out), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    frames.delete();
    exp_sym.delete();
    plan.delete();
    exp_under = 1'b0;
    reset     = 1'b0;
    aborting  = 1'b0;
    repeat (40) tick();
    random_slots(3, 0);
    start_frame(3);
    wait_done(400);

    // randomized frames with occasional starved slots
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(0, 9);
      random_slots(len, 20);
      repeat ($urandom_range(0, 20)) tick();
      start_frame(len);
      wait_done((PRE + len + GUARD + 3) * 16 + 40);
    end

    // longest payload: exactly 255 symbols, no counter wrap
    random_slots(255, 0);
    start_frame(255);
    wait_done((PRE + 255 + GUARD + 3) * 16 + 40);

    repeat (20) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
